// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit for the 5-stage pipeline: M/W forwarding, load-use stall,
// branch flush and a per-register scoreboard for the out-of-order
// long-latency (mul/div) unit.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating stall/flush
// cycle counters; without it StallCycles/FlushCycles are tied to zero.
module hazard_scoreboard_unit #(
    parameter int unsigned     REG_AW   = 5,
    parameter int unsigned     RS_W     = 2,
    parameter logic [RS_W-1:0] LOAD_SRC = 2'b01
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdD,
    input  logic              RegWriteD,
    input  logic              LongD,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [RS_W-1:0]   ResultSrcE,
    input  logic              PCSrcE,
    input  logic              LongIssueE,
    input  logic              LongBusy,
    input  logic              LongDone,
    input  logic [REG_AW-1:0] LongRd,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic [REG_AW:0]   PendingCnt,
    output logic [31:0]       StallCycles,
    output logic [31:0]       FlushCycles
);

    localparam int unsigned NREG = 1 << REG_AW;

    logic [NREG-1:0] pending_q, pending_d;
    logic [NREG-1:0] done_vec, issue_vec, visible;
    logic [REG_AW:0] cnt_q, cnt_d;
    logic            load_use, issue_raw, sb_raw, sb_waw, structural, stall_req;

    // Decode write-back clear and issue set; a register being written back
    // this cycle is already readable (write-before-read register file).
    always_comb begin
        done_vec  = '0;
        issue_vec = '0;
        if (LongDone)
            done_vec[LongRd] = 1'b1;
        if (LongIssueE && (RdE != '0))
            issue_vec[RdE] = 1'b1;
        visible   = pending_q & ~done_vec;
        pending_d = visible | issue_vec;
    end

    // Population count of the next scoreboard so the count moves with the bits.
    always_comb begin
        cnt_d = '0;
        for (int unsigned i = 0; i < NREG; i++)
            cnt_d = cnt_d + (REG_AW+1)'(pending_d[i]);
    end

    // Scoreboard bits and their registered count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    // Hazard terms; RdE/RdD nonzero checks also exclude x0 sources.
    always_comb begin
        load_use   = (ResultSrcE == LOAD_SRC) && (RdE != '0) &&
                     ((Rs1D == RdE) || (Rs2D == RdE));
        issue_raw  = LongIssueE && (RdE != '0) &&
                     ((Rs1D == RdE) || (Rs2D == RdE));
        sb_raw     = ((Rs1D != '0) && visible[Rs1D]) ||
                     ((Rs2D != '0) && visible[Rs2D]);
        sb_waw     = RegWriteD && (RdD != '0) && visible[RdD];
        structural = LongD && (LongBusy || LongIssueE);
        stall_req  = load_use | issue_raw | sb_raw | sb_waw | structural;
    end

    // Pipeline control and forwarding; reset forces the flushed, idle state.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b1;
        FlushE    = 1'b1;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (!reset) begin
            StallF = stall_req && !PCSrcE;
            StallD = stall_req && !PCSrcE;
            FlushD = PCSrcE;
            FlushE = stall_req || PCSrcE;
            if ((Rs1E != '0) && RegWriteM && (Rs1E == RdM))
                ForwardAE = 2'b10;
            else if ((Rs1E != '0) && RegWriteW && (Rs1E == RdW))
                ForwardAE = 2'b01;
            if ((Rs2E != '0) && RegWriteM && (Rs2E == RdM))
                ForwardBE = 2'b10;
            else if ((Rs2E != '0) && RegWriteW && (Rs2E == RdW))
                ForwardBE = 2'b01;
        end
    end

    assign PendingCnt = cnt_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cyc_q, flush_cyc_q;

    // Saturating performance counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cyc_q <= '0;
            flush_cyc_q <= '0;
        end else begin
            if (StallD && (stall_cyc_q != '1))
                stall_cyc_q <= stall_cyc_q + 32'd1;
            if ((FlushD || FlushE) && (flush_cyc_q != '1))
                flush_cyc_q <= flush_cyc_q + 32'd1;
        end
    end

    assign StallCycles = stall_cyc_q;
    assign FlushCycles = flush_cyc_q;
`else
    assign StallCycles = '0;
    assign FlushCycles = '0;
`endif

    // Issuing to a register that stays pending is a WAW the stall should have blocked.
    issue_onto_pending: assert property (@(posedge clk) disable iff (reset)
        !(LongIssueE && (RdE != '0) && visible[RdE]));

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed and randomized bench for hazard_scoreboard_unit with a
// rule-level reference model (pending set held as a bit array).
module tb_hazard_scoreboard_unit;

    localparam int unsigned AW   = 5;
    localparam int unsigned NREG = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, LongRd, RdM, RdW;
    logic          RegWriteD, LongD, PCSrcE, LongIssueE, LongBusy, LongDone;
    logic          RegWriteM, RegWriteW;
    logic [1:0]    ResultSrcE;
    logic          StallF, StallD, FlushD, FlushE;
    logic [1:0]    ForwardAE, ForwardBE;
    logic [AW:0]   PendingCnt;
    logic [31:0]   StallCycles, FlushCycles;

    hazard_scoreboard_unit #(.REG_AW(AW), .RS_W(2), .LOAD_SRC(2'b01)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD), .LongD(LongD),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .LongIssueE(LongIssueE), .LongBusy(LongBusy), .LongDone(LongDone), .LongRd(LongRd),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .PendingCnt(PendingCnt),
        .StallCycles(StallCycles), .FlushCycles(FlushCycles)
    );

    always #5 clk = ~clk;

    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned fails  = 0;

    // Reference state: which registers await a long-unit write-back, plus counters.
    bit          mp[NREG];
    int unsigned m_stall_cyc, m_flush_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] m_fwd(input logic [AW-1:0] r);
        if (r == 0) return 2'b00;
        if (RegWriteM && r == RdM) return 2'b10;
        if (RegWriteW && r == RdW) return 2'b01;
        return 2'b00;
    endfunction

    // A register still counts as outstanding unless written back this very cycle.
    function automatic bit m_outstanding(input logic [AW-1:0] r);
        return (r != 0) && mp[r] && !(LongDone && LongRd == r);
    endfunction

    function automatic bit m_stall_req();
        logic [AW-1:0] srcs[2];
        bit s = 0;
        srcs[0] = Rs1D;
        srcs[1] = Rs2D;
        foreach (srcs[k]) begin
            if (srcs[k] != 0) begin
                if (ResultSrcE == 2'b01 && RdE == srcs[k]) s = 1;
                if (LongIssueE && RdE == srcs[k]) s = 1;
                if (m_outstanding(srcs[k])) s = 1;
            end
        end
        if (RegWriteD && m_outstanding(RdD)) s = 1;
        if (LongD && (LongBusy || LongIssueE)) s = 1;
        return s;
    endfunction

    function automatic int unsigned m_count();
        int unsigned n = 0;
        foreach (mp[i]) n += mp[i];
        return n;
    endfunction

    task automatic check_all(input string tag);
        bit sr;
        sr = m_stall_req();
        check({tag, ".StallF"}, 32'(StallF), 32'(!reset && sr && !PCSrcE));
        check({tag, ".StallD"}, 32'(StallD), 32'(!reset && sr && !PCSrcE));
        check({tag, ".FlushD"}, 32'(FlushD), 32'(reset || PCSrcE));
        check({tag, ".FlushE"}, 32'(FlushE), 32'(reset || sr || PCSrcE));
        check({tag, ".FwdA"}, 32'(ForwardAE), reset ? 32'd0 : 32'(m_fwd(Rs1E)));
        check({tag, ".FwdB"}, 32'(ForwardBE), reset ? 32'd0 : 32'(m_fwd(Rs2E)));
        check({tag, ".PendCnt"}, 32'(PendingCnt), m_count());
`ifdef HAZARD_PERF_CNT_EN
        check({tag, ".StallCyc"}, StallCycles, m_stall_cyc);
        check({tag, ".FlushCyc"}, FlushCycles, m_flush_cyc);
`else
        check({tag, ".StallCyc"}, StallCycles, 32'd0);
        check({tag, ".FlushCyc"}, FlushCycles, 32'd0);
`endif
    endtask

    task automatic model_clear();
        foreach (mp[i]) mp[i] = 0;
        m_stall_cyc = 0;
        m_flush_cyc = 0;
    endtask

    // Advance one clock and update the model from the inputs held across the edge.
    task automatic tick();
        bit sr, st, fl;
        sr = m_stall_req();
        st = !reset && sr && !PCSrcE;
        fl = reset || sr || PCSrcE;
        @(posedge clk);
        if (reset) model_clear();
        else begin
            if (st) m_stall_cyc++;
            if (fl) m_flush_cyc++;
            if (LongDone) mp[LongRd] = 0;
            if (LongIssueE && RdE != 0) mp[RdE] = 1;
        end
        #1;
    endtask

    task automatic clear_inputs();
        Rs1D = '0; Rs2D = '0; RdD = '0; RegWriteD = 0; LongD = 0;
        Rs1E = '0; Rs2E = '0; RdE = '0; ResultSrcE = '0; PCSrcE = 0;
        LongIssueE = 0; LongBusy = 0; LongDone = 0; LongRd = '0;
        RdM = '0; RdW = '0; RegWriteM = 0; RegWriteW = 0;
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1;
        model_clear();
        #1;
        check_all(tag);
        reset = 0;
        #1;
    endtask

    initial begin
        int unsigned plist[$];
        logic [AW-1:0] cand;

        reset = 1;
        clear_inputs();
        model_clear();
        #2;
        check_all("reset");
        @(posedge clk); @(posedge clk); #1;
        reset = 0;
        #1;

        // Forwarding: M has priority over W; x0 never forwards
        Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
        #1; check_all("fwd_m"); check("fwd_m.AE10", 32'(ForwardAE), 32'd2);
        tick();
        clear_inputs(); Rs2E = 0; RdM = 0; RegWriteM = 1; Rs1E = 6; RdW = 6; RegWriteW = 1;
        #1; check_all("fwd_x0"); check("fwd_x0.BE00", 32'(ForwardBE), 32'd0);
        check("fwd_w.AE01", 32'(ForwardAE), 32'd1);
        tick();

        // Load-use stall for one cycle
        clear_inputs(); ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
        #1; check_all("ldu"); check("ldu.StallD1", 32'(StallD), 32'd1);
        tick();
        ResultSrcE = 2'b00;
        #1; check_all("ldu_after"); check("ldu_after.FlushE0", 32'(FlushE), 32'd0);
        tick();

        // Long RAW: stall on issue, hold while pending, release on write-back
        clear_inputs(); LongIssueE = 1; RdE = 9; Rs1D = 9;
        #1; check_all("raw_issue"); check("raw_issue.StallD1", 32'(StallD), 32'd1);
        tick();
        LongIssueE = 0; RdE = 0;
        for (int i = 0; i < 2; i++) begin
            #1; check_all("raw_wait"); check("raw_wait.Cnt1", 32'(PendingCnt), 32'd1);
            tick();
        end
        LongDone = 1; LongRd = 9;
        #1; check_all("raw_done"); check("raw_done.StallD0", 32'(StallD), 32'd0);
        tick();
        clear_inputs();
        #1; check_all("raw_clr"); check("raw_clr.Cnt0", 32'(PendingCnt), 32'd0);

        // WAW, structural and same-index set/clear
        LongIssueE = 1; RdE = 3;
        #1; check_all("waw_iss"); tick();
        clear_inputs(); RegWriteD = 1; RdD = 3;
        #1; check_all("waw"); check("waw.StallD1", 32'(StallD), 32'd1); tick();
        clear_inputs(); LongD = 1; LongBusy = 1;
        #1; check_all("struct"); check("struct.StallD1", 32'(StallD), 32'd1); tick();
        clear_inputs(); LongIssueE = 1; RdE = 4;
        #1; check_all("sc_iss"); tick();
        LongDone = 1; LongRd = 4;
        #1; check_all("sc_both"); tick();
        clear_inputs();
        #1; check_all("sc_after"); check("sc_after.Cnt2", 32'(PendingCnt), 32'd2);

        // Taken branch overrides a scoreboard stall
        Rs1D = 3; PCSrcE = 1;
        #1; check_all("br");
        check("br.StallF0", 32'(StallF), 32'd0); check("br.FlushD1", 32'(FlushD), 32'd1);
        tick();
        clear_inputs();
        LongDone = 1; LongRd = 3; #1; check_all("drain3"); tick();
        LongRd = 4; #1; check_all("drain4"); tick();
        clear_inputs();

        // Three load-use stall cycles after a fresh reset
        pulse_reset("cnt_rst");
        ResultSrcE = 2'b01; RdE = 8; Rs1D = 8;
        for (int i = 0; i < 3; i++) begin
            #1; check_all("cnt_stall"); tick();
        end
        clear_inputs();
        #1; check_all("cnt_end");
`ifdef HAZARD_PERF_CNT_EN
        check("cnt_end.Stall3", StallCycles, 32'd3);
`endif
        tick();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            clear_inputs();
            Rs1D = 5'($urandom_range(0, 15)); Rs2D = 5'($urandom_range(0, 15));
            RdD = 5'($urandom_range(0, 15));  RegWriteD = 1'($urandom_range(0, 1));
            LongD = ($urandom_range(0, 3) == 0); LongBusy = ($urandom_range(0, 2) == 0);
            Rs1E = 5'($urandom_range(0, 15)); Rs2E = 5'($urandom_range(0, 15));
            RdM = 5'($urandom_range(0, 15));  RdW = 5'($urandom_range(0, 15));
            RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
            ResultSrcE = 2'($urandom_range(0, 3));
            PCSrcE = ($urandom_range(0, 7) == 0);
            plist.delete();
            foreach (mp[i]) if (mp[i]) plist.push_back(i);
            if (plist.size() != 0 && $urandom_range(0, 2) == 0) begin
                LongDone = 1;
                LongRd = 5'(plist[$urandom_range(0, plist.size() - 1)]);
            end
            cand = 5'($urandom_range(0, 15));
            RdE = cand;
            if ($urandom_range(0, 3) == 0 && (cand == 0 || !mp[cand] || (LongDone && LongRd == cand)))
                LongIssueE = 1;
            #1; check_all("rand");
            tick();
        end

        // Asynchronous reset mid-stream with a register pending
        clear_inputs(); LongIssueE = 1; RdE = 9; #1; check_all("ar_iss"); tick();
        clear_inputs(); Rs1D = 9;
        #2;
        reset = 1;
        model_clear();
        #1;
        check_all("async_rst");
        check("async_rst.Cnt0", 32'(PendingCnt), 32'd0);
        @(posedge clk); #1;
        reset = 0;
        #1; check_all("post_rst"); tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard_unit.md
# hazard_scoreboard_unit

- Parametrised next-generation hazard unit for the 5-stage RISC-V pipeline (F/D/E/M/W).
- Covers M/W forwarding, load-use stall and branch flush, plus a per-register scoreboard for a multi-cycle long-latency unit (mul/div).
- The long unit writes back out of order, so the block also handles RAW, WAW and structural hazards against it.
- Sits beside the datapath and drives the F/D/E pipeline-register enables and flushes.

## Interface
Parameters:
- REG_AW, 5, register address width; scoreboard holds 2^REG_AW bits, bit 0 never set
- RS_W, 2, ResultSrc width
- LOAD_SRC, 2'b01, ResultSrcE encoding meaning "load"

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- Rs1D, Rs2D, RdD  in  REG_AW  D-stage register fields
- RegWriteD  in  1  D instruction writes Rd; long ops included
- LongD  in  1  D instruction is a long-latency op
- Rs1E, Rs2E, RdE  in  REG_AW  E-stage fields
- ResultSrcE  in  RS_W  E result source
- PCSrcE  in  1  taken branch/jump in E
- LongIssueE  in  1  E instruction handed to long unit this cycle
- LongBusy  in  1  long unit cannot accept an op
- LongDone  in  1  long unit writes register file this cycle
- LongRd  in  REG_AW  destination of LongDone
- RdM, RdW  in  REG_AW; RegWriteM, RegWriteW  in  1
- StallF, StallD, FlushD, FlushE  out  1
- ForwardAE, ForwardBE  out  2  00 regfile, 01 W, 10 M
- PendingCnt  out  REG_AW+1  number of set scoreboard bits
- StallCycles, FlushCycles  out  32  performance counters; see Configuration

## Operation
- Forwarding:
  - ForwardAE = 10 if Rs1E==RdM && RegWriteM && Rs1E!=0.
  - Otherwise 01 if the same test holds against RdW/RegWriteW.
  - Otherwise 00. ForwardBE is identical on Rs2E.
- Hazard terms (src = Rs1D or Rs2D, each only if !=0):
  - loadUse: ResultSrcE==LOAD_SRC && RdE!=0 && src==RdE.
  - issueRaw: LongIssueE && RdE!=0 && src==RdE. The pending bit is not yet visible.
  - sbRaw: pending[src] && !(LongDone && LongRd==src). The register file is write-before-read.
  - sbWaw: RegWriteD && RdD!=0 && pending[RdD] && !(LongDone && LongRd==RdD).
  - structural: LongD && (LongBusy || LongIssueE).
- stallReq = OR of all five terms.
- Outputs:
  - StallF = StallD = stallReq && !PCSrcE. A taken branch overrides the stall so the PC loads its target.
  - FlushD = PCSrcE.
  - FlushE = stallReq || PCSrcE.
- Scoreboard update at posedge:
  - LongDone clears pending[LongRd].
  - LongIssueE && RdE!=0 sets pending[RdE].
  - Set wins on the same index; different indices both apply.
- PendingCnt is the registered population count, updated in step with the bits.
- LongIssueE with pending[RdE] already set is a protocol violation, prevented by sbWaw. The simulation assertion fires.

## Timing
- Forward and stall/flush outputs are combinational from inputs and current scoreboard state; zero latency.
- Scoreboard set is visible to D from the cycle after issue. Clear is visible the same cycle as LongDone.
- Reset (async): pending all 0 and PendingCnt=0.
- While reset is high:
  - StallF=StallD=0, FlushD=FlushE=1, Forward*=00.
  - Counters are 0.
- Reset mid-operation discards all pending bits. The long unit is reset by the same signal.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - StallCycles increments each cycle StallD=1.
  - FlushCycles increments each cycle FlushE=1 or FlushD=1.
  - Both saturate at 32'hFFFFFFFF and are cleared by reset.
- Undefined: both ports are tied to 0 and no counter flops are built.

## Test plan
- Forwarding:
  - Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10.
  - Rs2E=0 with matching RdM=0 -> ForwardBE=00.
- Load-use: ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle. Next cycle (ResultSrcE=00), all stall/flush outputs are 0.
- Long RAW:
  - Issue: LongIssueE, RdE=9; Rs1D=9 in D -> stall that cycle, pending[9]=1 and PendingCnt=1 next cycle.
  - Wait: stall holds until the LongDone, LongRd=9 cycle, in which StallD=0 and PendingCnt is 0 after the edge.
- WAW/structural:
  - pending[3]=1, RegWriteD=1, RdD=3 -> StallD=1.
  - LongD=1, LongBusy=1 -> StallD=1.
  - Set/clear same index: LongIssueE RdE=4 with LongDone LongRd=4 -> pending[4] stays 1.
- Branch override: sbRaw active and PCSrcE=1 -> StallF=StallD=0, FlushD=FlushE=1.
- Reset/counters (macro on):
  - 3 stall cycles -> StallCycles=3.
  - Async reset mid-stream with pending[9]=1 -> PendingCnt=0 and counters 0 immediately, without waiting for clk.
